// File: rtl/engine_tone_gen.sv
// -----------------------------------------------------------------------------
// engine_tone_gen
//
// Engine-sound sample generator for the racing game audio path. A 16-bit
// phase accumulator produces a sawtooth whose pitch follows the car speed.
// Its amplitude is scaled by a volume that a small state machine fades in and
// out. The 8-bit result feeds the duty input of the downstream 8-bit PWM
// audio stage. Midscale (128) is silence.
//
// Optional build macro:
//   ENGINE_SQUARE_MIX_EN  - when defined, the sawtooth is averaged with a
//                           square wave taken from phase[15]. This gives a
//                           harsher, growl-like tone. Scaling and state
//                           behaviour are unchanged.
//
// Ports:
//   clk          in   1  system clock (100 MHz)
//   rst_n        in   1  asynchronous active-low reset
//   en           in   1  level: 1 = engine audible, 0 = fade to silence
//   speed        in   8  unsigned car speed
//   speed_valid  in   1  one-cycle strobe; speed is captured while high
//   duty         out  8  audio sample for the PWM duty input
//   sample_tick  out  1  one-cycle pulse marking each sample update
//   busy         out  1  high whenever the state machine is not IDLE
// -----------------------------------------------------------------------------
module engine_tone_gen #(
   parameter int unsigned SAMPLE_DIV = 256,  // clocks per sample, 2..65535
   parameter int unsigned BASE_INC   = 40,   // idle phase increment, 0..1024
   parameter int unsigned SPEED_GAIN = 32,   // increment per speed unit, 0..64
   parameter int unsigned VOL_STEP   = 4     // volume step per sample, 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] speed,
   input  logic       speed_valid,
   output logic [7:0] duty,
   output logic       sample_tick,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_IN  = 2'd1,
      RUN      = 2'd2,
      FADE_OUT = 2'd3
   } state_t;

   localparam int unsigned DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [15:0]      BASE16   = 16'(BASE_INC);
   localparam logic [15:0]      GAIN16   = 16'(SPEED_GAIN);
   localparam logic [8:0]       STEP9    = 9'(VOL_STEP);
   localparam logic [7:0]       STEP8    = 8'(VOL_STEP);
   localparam logic [7:0]       MIDSCALE = 8'd128;
   localparam logic [7:0]       VOL_MAX  = 8'hFF;

   // Registered state
   state_t           state_q;
   logic [DIV_W-1:0] divider;
   logic [7:0]       speed_reg;
   logic [15:0]      phase_q;
   logic [7:0]       vol_q;

   // Next-state values
   state_t      state_d;
   logic [15:0] phase_d;
   logic [7:0]  vol_d;
   logic [7:0]  duty_d;

   // Datapath
   logic               tick;
   logic [15:0]        inc;
   logic [7:0]         wave;
   logic signed [8:0]  s;
   logic signed [17:0] s_ext;
   logic signed [17:0] v_ext;
   logic [7:0]         duty_calc;
   logic [8:0]         vol_up_sum;
   logic [7:0]         vol_up;
   logic [7:0]         vol_dn;

   // ---------------------------------------------------------------------------
   // Sample divider: tick is high on the last count of each period. Updates
   // happen on that edge, and sample_tick is the registered copy, so the pulse
   // lines up with the cycle in which the new duty value first appears.
   // ---------------------------------------------------------------------------
   assign tick = (divider == DIV_LAST);

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divider     <= '0;
         sample_tick <= 1'b0;
      end else begin
         divider     <= tick ? '0 : divider + 1'b1;
         sample_tick <= tick;
      end
   end

   // Speed capture. The last strobe wins. inc reads speed_reg, so a capture
   // first moves the phase on the next tick after the capture edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed_reg <= '0;
      end else if (speed_valid) begin
         speed_reg <= speed;
      end
   end

   // The parameter limits keep this below 2^16, so no overflow is possible.
   assign inc = BASE16 + 16'(speed_reg) * GAIN16;

   // ---------------------------------------------------------------------------
   // Waveform and amplitude scaling from the pre-update phase and volume
   // ---------------------------------------------------------------------------
`ifdef ENGINE_SQUARE_MIX_EN
   // A 9-bit sum of saw and square, halved back to 8 bits.
   assign wave = 8'(({1'b0, phase_q[15:8]} + (phase_q[15] ? 9'd255 : 9'd0)) >> 1);
`else
   assign wave = phase_q[15:8];
`endif

   assign s     = $signed({1'b0, wave}) - 9'sd128;   // -128..127
   assign s_ext = 18'(s);
   assign v_ext = {10'd0, vol_q};

   // The arithmetic shift floors toward -inf, giving -128..126. Adding
   // midscale modulo 256 then yields 0..254 without a wider intermediate.
   assign duty_calc = 8'((s_ext * v_ext) >>> 8) + MIDSCALE;

   // Saturating volume steps
   assign vol_up_sum = {1'b0, vol_q} + STEP9;
   assign vol_up     = vol_up_sum[8] ? VOL_MAX : vol_up_sum[7:0];
   assign vol_dn     = (vol_q <= STEP8) ? 8'd0 : vol_q - STEP8;

   // ---------------------------------------------------------------------------
   // State machine: next state, phase, volume and duty
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      vol_d   = vol_q;
      duty_d  = duty;

      if (tick && state_q != IDLE) begin
         phase_d = phase_q + inc;
         duty_d  = duty_calc;
      end

      unique case (state_q)
         IDLE: begin
            phase_d = '0;
            vol_d   = '0;
            duty_d  = MIDSCALE;
            if (en) state_d = FADE_IN;
         end

         FADE_IN: begin
            if (tick) vol_d = vol_up;
            // An en change on a tick cycle still applies this state's vol step.
            if (!en)                          state_d = FADE_OUT;
            else if (tick && vol_up == VOL_MAX) state_d = RUN;
         end

         RUN: begin
            if (!en) state_d = FADE_OUT;
         end

         FADE_OUT: begin
            if (tick) vol_d = vol_dn;
            if (en) begin
               state_d = FADE_IN;
            end else if (tick && vol_dn == 8'd0) begin
               state_d = IDLE;
               phase_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         vol_q   <= '0;
         duty    <= MIDSCALE;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         vol_q   <= vol_d;
         duty    <= duty_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_engine_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_engine_tone_gen
//
// Self-checking bench for engine_tone_gen. A behavioural model, written in
// plain integer arithmetic, predicts duty, sample_tick and busy. One compare
// process checks them on every falling clock edge while out of reset. Directed
// stimulus walks through idle, fade-in, speed changes, fade-out, resume from a
// partial volume, and an asynchronous reset during a fade. Hand-computed
// literal values pin key points.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_engine_tone_gen;

   localparam int SAMPLE_DIV = 256;
   localparam int BASE_INC   = 40;
   localparam int SPEED_GAIN = 32;
   localparam int VOL_STEP   = 4;

   localparam int M_IDLE = 0;
   localparam int M_IN   = 1;
   localparam int M_RUN  = 2;
   localparam int M_OUT  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] speed;
   logic       speed_valid;
   logic [7:0] duty;
   logic       sample_tick;
   logic       busy;

   int n_vec  = 0;
   int n_miss = 0;
   bit cmp_en = 1'b0;

   // Model state
   int m_div   = 0;
   int m_stick = 0;
   int m_phase = 0;
   int m_vol   = 0;
   int m_speed = 0;
   int m_duty  = 128;
   int m_mode  = M_IDLE;

   engine_tone_gen #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .BASE_INC   (BASE_INC),
      .SPEED_GAIN (SPEED_GAIN),
      .VOL_STEP   (VOL_STEP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .speed       (speed),
      .speed_valid (speed_valid),
      .duty        (duty),
      .sample_tick (sample_tick),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_vec++;
      if (actual !== expected) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Sample value for a given phase and volume: centre the waveform on zero,
   // scale it by vol/256 rounding toward -inf, then re-centre on midscale.
   function automatic int model_duty(input int phase, input int vol);
      int w;
      int p;
`ifdef ENGINE_SQUARE_MIX_EN
      w = ((phase / 256) + ((phase >= 32768) ? 255 : 0)) / 2;
`else
      w = phase / 256;
`endif
      p = (w - 128) * vol;
      // The offset keeps the dividend positive, so integer division floors.
      return 128 + (p + 65536) / 256 - 256;
   endfunction

   task automatic model_reset();
      m_div   = 0;
      m_stick = 0;
      m_phase = 0;
      m_vol   = 0;
      m_speed = 0;
      m_duty  = 128;
      m_mode  = M_IDLE;
   endtask

   task automatic model_step();
      bit tick;
      int nvol;
      tick    = (m_div == SAMPLE_DIV - 1);
      nvol    = m_vol;
      m_stick = tick ? 1 : 0;
      m_div   = tick ? 0 : m_div + 1;
      if (m_mode == M_IDLE) begin
         m_duty = 128;
      end else if (tick) begin
         m_duty  = model_duty(m_phase, m_vol);
         m_phase = (m_phase + BASE_INC + m_speed * SPEED_GAIN) % 65536;
      end
      if (tick && m_mode == M_IN)  nvol = (m_vol + VOL_STEP > 255) ? 255 : m_vol + VOL_STEP;
      if (tick && m_mode == M_OUT) nvol = (m_vol < VOL_STEP) ? 0 : m_vol - VOL_STEP;
      case (m_mode)
         M_IDLE: if (en) m_mode = M_IN;
         M_IN: begin
            if (!en) m_mode = M_OUT;
            else if (tick && nvol == 255) m_mode = M_RUN;
         end
         M_RUN: if (!en) m_mode = M_OUT;
         default: begin
            if (en) m_mode = M_IN;
            else if (tick && nvol == 0) begin
               m_mode  = M_IDLE;
               m_phase = 0;
            end
         end
      endcase
      if (m_mode == M_IDLE) nvol = 0;
      m_vol = nvol;
      if (speed_valid) m_speed = int'(speed);
   endtask

   // Model advances on the same edges as the DUT.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Per-cycle compare, sampled away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && cmp_en) begin
            check("duty", int'(duty), m_duty);
            check("sample_tick", int'(sample_tick), m_stick);
            check("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
         end
      end
   end

   // Wait for n sample_tick pulses, bounded by a cycle budget.
   task automatic wait_ticks(input int n);
      int seen;
      int cyc;
      seen = 0;
      cyc  = 0;
      while (seen < n && cyc < (n + 1) * SAMPLE_DIV) begin
         @(negedge clk);
         cyc++;
         if (sample_tick) seen++;
      end
      check("tick_wait", seen, n);
   endtask

   task automatic pulse_speed(input logic [7:0] v);
      speed       = v;
      speed_valid = 1'b1;
      @(negedge clk);
      speed_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      en          = 1'b0;
      speed       = 8'd0;
      speed_valid = 1'b0;

`ifndef ENGINE_SQUARE_MIX_EN
      // Pin the model's scaling against hand-computed values.
      check("model_mid",  model_duty(32'h8000, 255), 128);
      check("model_top",  model_duty(32'hFF00, 255), 254);
      check("model_bot",  model_duty(0, 255), 0);
`endif

      repeat (3) @(negedge clk);
      check("reset_duty", int'(duty), 128);
      check("reset_busy", int'(busy), 0);
      check("reset_tick", int'(sample_tick), 0);

      // Idle with en low for ten sample periods
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      wait_ticks(10);
      check("idle_duty", int'(duty), 128);
      check("idle_busy", int'(busy), 0);

      // Fade in to full volume at speed 0
      en = 1'b1;
      wait_ticks(64);
      check("run_busy", int'(busy), 1);
`ifndef ENGINE_SQUARE_MIX_EN
      // Tick 64: phase 2520 (saw 9), vol 252 -> 128 + floor(-119*252/256) = 10
      check("tick64_duty", int'(duty), 10);
`endif

      // Speed change mid-period, then the maximum speed (phase wraps)
      repeat (100) @(negedge clk);
      pulse_speed(8'd10);
      wait_ticks(3);
      repeat (37) @(negedge clk);
      pulse_speed(8'd255);
      wait_ticks(12);

      // Fade out completely
      en = 1'b0;
      wait_ticks(64);
      @(negedge clk);
      check("faded_duty", int'(duty), 128);
      check("faded_busy", int'(busy), 0);

      // Partial fade-in to vol 100, brief fade-out, resume from 100
      en = 1'b1;
      wait_ticks(25);
      en = 1'b0;
      @(negedge clk);
      check("fade_out_busy", int'(busy), 1);
      en = 1'b1;
      wait_ticks(10);
      check("resume_busy", int'(busy), 1);

      // Asynchronous reset during fade-in
      #2 rst_n = 1'b0;
      #1;
      check("async_duty", int'(duty), 128);
      check("async_busy", int'(busy), 0);
      check("async_tick", int'(sample_tick), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Restart from a clean reset: tick 2 uses phase 40, vol 4 -> 126
      wait_ticks(2);
      check("restart_duty2", int'(duty), 126);
      wait_ticks(1);
      check("restart_duty3", int'(duty), 124);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
